// File: rtl/stream_arb_2to1.sv
`default_nettype none
// ============================================================================
// Module   : stream_arb_2to1
// Purpose  : Packet-aware round-robin arbiter merging two valid/ready streams
//            (A, B) into one registered output stage. A packet, once started,
//            owns the output until its last beat is accepted; the other
//            source is blocked meanwhile. Priority toggles only on packet
//            completion.
// Ports    : clk, rst_n            clock, async active-low reset
//            in_a_*_i / in_a_ready_o  source A beat (valid, data, last) / ready
//            in_b_*_i / in_b_ready_o  source B beat (valid, data, last) / ready
//            out_valid_o, out_data_o, out_last_o, out_sel_o  registered beat,
//                                     out_sel_o is the mux select (0=A, 1=B)
//            out_ready_i              downstream accept
// Revision : 1.0 - initial release
// ============================================================================
module stream_arb_2to1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_a_valid_i,
  input  logic [WIDTH-1:0] in_a_data_i,
  input  logic             in_a_last_i,
  output logic             in_a_ready_o,
  input  logic             in_b_valid_i,
  input  logic [WIDTH-1:0] in_b_data_i,
  input  logic             in_b_last_i,
  output logic             in_b_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_last_o,
  output logic             out_sel_o,
  input  logic             out_ready_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;      // 0 = A has priority, 1 = B
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_sel_q, out_sel_d;

  logic             load;
  logic             grant_a, grant_b;
  logic             accept_a, accept_b;

  // The output register can take a new beat when empty or being drained.
  assign load = ~out_valid_q | out_ready_i;

  // Grant selection. In IDLE a grant requires the source to be valid, so at
  // most one grant is ever high. In a LOCK state the owner keeps its grant
  // even while it idles; its own valid decides whether a beat is taken.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      IDLE: begin
        grant_a = in_a_valid_i & (~in_b_valid_i | ~prio_q);
        grant_b = in_b_valid_i & (~in_a_valid_i |  prio_q);
      end
      LOCK_A:  grant_a = 1'b1;
      LOCK_B:  grant_b = 1'b1;
      default: ;
    endcase
  end

  // rst_n gates the readys so nothing looks accepted while held in reset
  // (the empty output register would otherwise report load=1).
  assign in_a_ready_o = rst_n & load & grant_a;
  assign in_b_ready_o = rst_n & load & grant_b;

  assign accept_a = in_a_valid_i & in_a_ready_o;
  assign accept_b = in_b_valid_i & in_b_ready_o;

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;

    if (accept_a) begin
      out_valid_d = 1'b1;
      out_data_d  = in_a_data_i;
      out_last_d  = in_a_last_i;
      out_sel_d   = 1'b0;
      if (in_a_last_i) begin
        state_d = IDLE;
        prio_d  = 1'b1;
      end else begin
        state_d = LOCK_A;
      end
    end else if (accept_b) begin
      out_valid_d = 1'b1;
      out_data_d  = in_b_data_i;
      out_last_d  = in_b_last_i;
      out_sel_d   = 1'b1;
      if (in_b_last_i) begin
        state_d = IDLE;
        prio_d  = 1'b0;
      end else begin
        state_d = LOCK_B;
      end
    end else if (out_ready_i) begin
      // Beat drained with nothing to replace it; payload fields hold.
      out_valid_d = 1'b0;
    end

    // Recover from the unused encoding.
    if (state_q != IDLE && state_q != LOCK_A && state_q != LOCK_B) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign out_sel_o   = out_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_arb_2to1.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_arb_2to1
// Purpose  : Self-checking bench for stream_arb_2to1: directed scenarios
//            followed by random traffic against a packet-level reference
//            model (current owner, priority, output slot contents).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_arb_2to1;

  logic       clk;
  logic       rst_n;
  logic [1:0] sv;          // per-source valid (0=A, 1=B)
  logic [7:0] sd [2];      // per-source data
  logic [1:0] sl;          // per-source last
  logic       out_ready;
  logic       a_ready, b_ready;
  logic       out_valid, out_last, out_sel;
  logic [7:0] out_data;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: who owns the output (-1 none), whose turn it is,
  // and what the single output slot holds.
  int         m_owner;
  int         m_prio;
  bit         m_full;
  logic [7:0] m_data;
  bit         m_last;
  bit         m_sel;

  logic       obs_ar, obs_br;
  bit  [1:0]  acc;
  int         rem [2];

  stream_arb_2to1 #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_a_valid_i (sv[0]),
    .in_a_data_i  (sd[0]),
    .in_a_last_i  (sl[0]),
    .in_a_ready_o (a_ready),
    .in_b_valid_i (sv[1]),
    .in_b_data_i  (sd[1]),
    .in_b_last_i  (sl[1]),
    .in_b_ready_o (b_ready),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_last_o   (out_last),
    .out_sel_o    (out_sel),
    .out_ready_i  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_prio  = 0;
    m_full  = 1'b0;
    m_data  = 8'h00;
    m_last  = 1'b0;
    m_sel   = 1'b0;
  endtask

  // One clock of traffic: predict which source may hand over a beat, check
  // the readys, advance the model across the edge, check the output slot.
  task automatic tick();
    int pick;
    bit ea, eb;
    int src;
    #1;
    pick = -1;
    if (m_owner >= 0)          pick = m_owner;
    else if (sv[0] && sv[1])   pick = m_prio;
    else if (sv[0])            pick = 0;
    else if (sv[1])            pick = 1;
    ea = (!m_full || out_ready) && (pick == 0);
    eb = (!m_full || out_ready) && (pick == 1);
    obs_ar = a_ready;
    obs_br = b_ready;
    chk("a_ready", {31'd0, obs_ar}, {31'd0, ea});
    chk("b_ready", {31'd0, obs_br}, {31'd0, eb});
    acc[0] = ea && sv[0];
    acc[1] = eb && sv[1];
    @(posedge clk);
    if (acc != 2'b00) begin
      src    = acc[1] ? 1 : 0;
      m_full = 1'b1;
      m_data = sd[src];
      m_last = sl[src];
      m_sel  = (src == 1);
      if (sl[src]) begin
        m_owner = -1;
        m_prio  = 1 - src;
      end else begin
        m_owner = src;
      end
    end else if (out_ready) begin
      m_full = 1'b0;
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
    chk("out_data",  {24'd0, out_data},  {24'd0, m_data});
    chk("out_last",  {31'd0, out_last},  {31'd0, m_last});
    chk("out_sel",   {31'd0, out_sel},   {31'd0, m_sel});
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Random source: a held beat only changes after it was accepted.
  task automatic gen_beat(input int s);
    if (rem[s] == 0) rem[s] = $urandom_range(1, 4);
    rem[s]--;
    sd[s] = 8'($urandom);
    sl[s] = (rem[s] == 0);
    sv[s] = 1'b1;
  endtask

  initial begin
    int ai;
    logic [7:0] exp4 [4];
    exp4[0] = 8'hA0; exp4[1] = 8'hA1; exp4[2] = 8'hA2; exp4[3] = 8'hB0;
    rem[0] = 0; rem[1] = 0;

    // 1: reset held with both sources valid
    rst_n = 1'b0;
    out_ready = 1'b1;
    sv = 2'b11; sd[0] = 8'h01; sd[1] = 8'h02; sl = 2'b11;
    model_reset();
    #3;
    chk("t1_a_ready",  {31'd0, a_ready},   32'd0);
    chk("t1_b_ready",  {31'd0, b_ready},   32'd0);
    chk("t1_out_valid",{31'd0, out_valid}, 32'd0);
    chk("t1_out_sel",  {31'd0, out_sel},   32'd0);
    @(posedge clk); #1;
    chk("t1_hold_valid",{31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;

    // 2: single beat from A only
    sv = 2'b01; sd[0] = 8'h11; sl[0] = 1'b1;
    tick();
    chk("t2_a_ready", {31'd0, obs_ar},   32'd1);
    chk("t2_data",    {24'd0, out_data}, 32'h11);
    chk("t2_valid",   {31'd0, out_valid},32'd1);
    chk("t2_last",    {31'd0, out_last}, 32'd1);
    chk("t2_sel",     {31'd0, out_sel},  32'd0);
    sv = 2'b00;

    // 3: both always valid, single-beat packets, from reset: 0,1,0,1
    apply_reset();
    sv = 2'b11; sd[0] = 8'h30; sd[1] = 8'h40; sl = 2'b11; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_sel",   {31'd0, out_sel},   32'(i % 2));
      chk("t3_valid", {31'd0, out_valid}, 32'd1);
    end
    sv = 2'b00;

    // 4: three-beat A packet must not be interleaved with B
    ai = 0;
    sv = 2'b11; sd[0] = 8'hA0; sl[0] = 1'b0; sd[1] = 8'hB0; sl[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_data",  {24'd0, out_data}, {24'd0, exp4[i]});
      chk("t4_b_rdy", {31'd0, obs_br},   (i == 3) ? 32'd1 : 32'd0);
      if (acc[0]) begin
        ai++;
        if (ai < 3) begin
          sd[0] = 8'hA0 + 8'(ai);
          sl[0] = (ai == 2);
        end else begin
          sv[0] = 1'b0;
        end
      end
      if (acc[1]) sv[1] = 1'b0;
    end

    // 5: backpressure holds the output and blocks both sources
    sv = 2'b01; sd[0] = 8'h5C; sl[0] = 1'b1; out_ready = 1'b1;
    tick();
    chk("t5_load", {24'd0, out_data}, 32'h5C);
    sv = 2'b10; sd[1] = 8'h77; sl[1] = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_data", {24'd0, out_data}, 32'h5C);
      chk("t5_a_rdy",     {31'd0, obs_ar},   32'd0);
      chk("t5_b_rdy",     {31'd0, obs_br},   32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("t5_next", {24'd0, out_data}, 32'h77);
    sv = 2'b00;
    tick();
    chk("t5_drain", {31'd0, out_valid}, 32'd0);

    // 6: reset in the middle of a B packet
    sv = 2'b10; sd[1] = 8'hB1; sl[1] = 1'b0;
    tick();
    sd[1] = 8'hB2;
    tick();
    sd[1] = 8'hB3; sl[1] = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    sv = 2'b11; sd[0] = 8'hAA; sl[0] = 1'b1;
    tick();
    chk("t6_a_first", {31'd0, obs_ar},   32'd1);
    chk("t6_b_block", {31'd0, obs_br},   32'd0);
    chk("t6_data",    {24'd0, out_data}, 32'hAA);
    chk("t6_sel",     {31'd0, out_sel},  32'd0);
    sv = 2'b00;

    // Random traffic with random backpressure
    apply_reset();
    rem[0] = 0; rem[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      for (int s = 0; s < 2; s++) begin
        if (acc[s]) begin
          sv[s] = 1'b0;
          if ($urandom_range(0, 3) != 0) gen_beat(s);
        end else if (!sv[s]) begin
          if ($urandom_range(0, 1) == 1) gen_beat(s);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
